// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives IMEM and feeds decode through a
// one-entry valid/ready slot. Jumps (op 2'b11) are resolved here and never issued.
module fetch_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 32,
    parameter int RESET_PC  = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_data,
    output logic [7:0]        instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [1:0]        fetch_state,
    output logic [15:0]       issue_count
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    typedef struct packed {
        logic [7:0]        instr;
        logic [ADDR_W-1:0] pc;
        logic              valid;
    } slot_t;

    // Masking keeps the PC modulo MEM_DEPTH and the upper address bits at zero.
    localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC) & PC_MASK;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    slot_t             slot, slot_n;
    logic [15:0]       issue_cnt;

    logic              fire, slot_free, is_j;
    logic [ADDR_W-1:0] pc_seq, pc_jmp, pc_redir;

    assign fire      = slot.valid & instr_ready;
    assign slot_free = !slot.valid | instr_ready;
    assign is_j      = (imem_data[7:6] == 2'b11);
    assign pc_seq    = (pc + ADDR_W'(1)) & PC_MASK;
    assign pc_jmp    = (pc + ADDR_W'(1) + ADDR_W'(imem_data[1:0])) & PC_MASK;
    assign pc_redir  = redirect_pc & PC_MASK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RESET;
            pc        <= PC_INIT;
            slot      <= '0;
            issue_cnt <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            slot      <= slot_n;
            if (fire) issue_cnt <= issue_cnt + 16'd1;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        slot_n       = slot;
        // A completed handshake empties the slot unless a new fetch refills it below.
        slot_n.valid = slot.valid & !instr_ready;
        case (state)
            ST_RESET: state_n = halt ? ST_HALTED : ST_RUN;
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_n         = pc_redir;
                    slot_n.valid = 1'b0;
                end else if (halt) begin
                    state_n = ST_HALTED;
                end else if (slot_free) begin
                    if (is_j) begin
                        pc_n = pc_jmp;
                    end else begin
                        slot_n.instr = imem_data;
                        slot_n.pc    = pc;
                        slot_n.valid = 1'b1;
                        pc_n         = pc_seq;
                    end
                end
            end
            ST_HALTED: begin
                if (redirect_valid) begin
                    pc_n         = pc_redir;
                    slot_n.valid = 1'b0;
                end
                if (!halt) state_n = ST_RUN;
            end
            default: state_n = ST_RESET;
        endcase
    end

    assign imem_addr   = pc;
    assign instr       = slot.instr;
    assign instr_pc    = slot.pc;
    assign instr_valid = slot.valid;
    assign fetch_state = state;
    assign issue_count = issue_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, streaming, jumps, backpressure,
// redirects, wrap-around and halt, with hand-computed expectations.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [7:0]  imem_data;
    logic [7:0]  instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        halt;
    logic [1:0]  fetch_state;
    logic [15:0] issue_count;

    logic [7:0]  mem [32];
    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.ADDR_W(8), .MEM_DEPTH(32), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .fetch_state(fetch_state),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 8'd32) ? mem[imem_addr[4:0]] : 8'h00;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full view of the slot, PC and counter after an edge.
    task automatic chk_all(input string tag, input logic v, input logic [7:0] ins,
                           input logic [7:0] ipc, input logic [7:0] addr, input logic [15:0] cnt);
        chk({tag, ".valid"}, 16'(instr_valid), 16'(v));
        if (v) begin
            chk({tag, ".instr"}, 16'(instr), 16'(ins));
            chk({tag, ".pc"}, 16'(instr_pc), 16'(ipc));
        end
        chk({tag, ".addr"}, 16'(imem_addr), 16'(addr));
        chk({tag, ".count"}, issue_count, cnt);
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        mem[0]  = 8'h49; mem[1]  = 8'hC1; mem[2]  = 8'h18; mem[3]  = 8'hA9;
        mem[4]  = 8'h24; mem[5]  = 8'h35; mem[6]  = 8'h56; mem[7]  = 8'h67;
        mem[20] = 8'h49; mem[21] = 8'hC3; mem[25] = 8'h5D;
        mem[29] = 8'h7B; mem[30] = 8'h8A; mem[31] = 8'hC0;

        rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00; halt = 1'b0;
        tick(); tick();
        chk("rst.state", 16'(fetch_state), 16'h0);
        chk("rst.instr", 16'(instr), 16'h0);
        chk("rst.ipc", 16'(instr_pc), 16'h0);
        chk_all("rst", 1'b0, 8'h00, 8'h00, 8'd0, 16'd0);

        // T2: RESET takes one cycle, then stream with j at pc1 skipping pc2
        rst = 1'b0;
        tick();
        chk("t2.state_run", 16'(fetch_state), 16'h1);
        chk_all("t2.c1", 1'b0, 8'h00, 8'h00, 8'd0, 16'd0);
        tick(); chk_all("t2.pc0", 1'b1, 8'h49, 8'd0, 8'd1, 16'd0);
        tick(); chk_all("t2.jbubble", 1'b0, 8'h00, 8'h00, 8'd3, 16'd1);
        tick(); chk_all("t2.pc3", 1'b1, 8'hA9, 8'd3, 8'd4, 16'd1);

        // T3: backpressure holds everything stable
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); chk_all("t3.stall", 1'b1, 8'hA9, 8'd3, 8'd4, 16'd1);
        end
        instr_ready = 1'b1;
        tick(); chk_all("t3.pc4", 1'b1, 8'h24, 8'd4, 8'd5, 16'd2);
        tick(); chk_all("t3.pc5", 1'b1, 8'h35, 8'd5, 8'd6, 16'd3);
        tick(); chk_all("t4.pc6", 1'b1, 8'h56, 8'd6, 8'd7, 16'd4);

        // T4: redirect flushes a stalled slot
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'd20;
        tick(); chk_all("t4.flush", 1'b0, 8'h00, 8'h00, 8'd20, 16'd4);
        instr_ready = 1'b1; redirect_valid = 1'b0;
        tick(); chk_all("t4.pc20", 1'b1, 8'h49, 8'd20, 8'd21, 16'd4);
        tick(); chk_all("t4.j_imm3", 1'b0, 8'h00, 8'h00, 8'd25, 16'd5);
        tick(); chk_all("t4.pc25", 1'b1, 8'h5D, 8'd25, 8'd26, 16'd5);

        // T5: redirect with a handshake in the same cycle still counts; wrap at 31
        redirect_valid = 1'b1; redirect_pc = 8'd30;
        tick(); chk_all("t5.redir_fire", 1'b0, 8'h00, 8'h00, 8'd30, 16'd6);
        redirect_valid = 1'b0;
        tick(); chk_all("t5.pc30", 1'b1, 8'h8A, 8'd30, 8'd31, 16'd6);
        tick(); chk_all("t5.j31_wrap", 1'b0, 8'h00, 8'h00, 8'd0, 16'd7);
        tick(); chk_all("t5.pc0", 1'b1, 8'h49, 8'd0, 8'd1, 16'd7);
        redirect_valid = 1'b1; redirect_pc = 8'hFD;
        tick(); chk_all("t5.redir_mod", 1'b0, 8'h00, 8'h00, 8'd29, 16'd8);
        redirect_valid = 1'b0;
        tick(); chk_all("t5.pc29", 1'b1, 8'h7B, 8'd29, 8'd30, 16'd8);
        tick(); chk_all("t5.pc30b", 1'b1, 8'h8A, 8'd30, 8'd31, 16'd9);
        tick(); chk_all("t5.j31b", 1'b0, 8'h00, 8'h00, 8'd0, 16'd10);
        tick(); chk_all("t5.pc0b", 1'b1, 8'h49, 8'd0, 8'd1, 16'd10);

        // T6: halt keeps a stalled slot, which then drains while halted
        instr_ready = 1'b0; halt = 1'b1;
        tick();
        chk("t6.state_halt", 16'(fetch_state), 16'h2);
        chk_all("t6.held", 1'b1, 8'h49, 8'd0, 8'd1, 16'd10);
        instr_ready = 1'b1;
        tick(); chk_all("t6.drain", 1'b0, 8'h00, 8'h00, 8'd1, 16'd11);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6.idle_state", 16'(fetch_state), 16'h2);
            chk_all("t6.idle", 1'b0, 8'h00, 8'h00, 8'd1, 16'd11);
        end
        redirect_valid = 1'b1; redirect_pc = 8'd4;
        tick();
        chk("t6.hredir_state", 16'(fetch_state), 16'h2);
        chk_all("t6.hredir", 1'b0, 8'h00, 8'h00, 8'd4, 16'd11);
        redirect_valid = 1'b0; halt = 1'b0;
        tick();
        chk("t6.resume_state", 16'(fetch_state), 16'h1);
        chk_all("t6.resume", 1'b0, 8'h00, 8'h00, 8'd4, 16'd11);
        tick(); chk_all("t6.pc4", 1'b1, 8'h24, 8'd4, 8'd5, 16'd11);
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'd6;
        tick();
        chk("t6.redir_wins_state", 16'(fetch_state), 16'h1);
        chk_all("t6.redir_wins", 1'b0, 8'h00, 8'h00, 8'd6, 16'd12);
        halt = 1'b0; redirect_valid = 1'b0;
        tick(); chk_all("t6.pc6", 1'b1, 8'h56, 8'd6, 8'd7, 16'd12);

        // T1: asynchronous reset mid-stream, away from any clock edge
        #2 rst = 1'b1;
        #1;
        chk("t1.async_state", 16'(fetch_state), 16'h0);
        chk_all("t1.async", 1'b0, 8'h00, 8'h00, 8'd0, 16'd0);
        tick();
        rst = 1'b0;
        tick(); chk_all("t1.c1", 1'b0, 8'h00, 8'h00, 8'd0, 16'd0);
        tick(); chk_all("t1.c2", 1'b1, 8'h49, 8'd0, 8'd1, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
